// File: rtl/tpuv2_pkg.sv
// tpuv2_pkg
// Shared constants for the tpuv2 matmul controller: default configuration,
// host address map, FSM state encoding and helpers that derive the number of
// host words per matrix row and index widths.
package tpuv2_pkg;

    localparam int TPU_DIM     = 8;
    localparam int TPU_BITS_AB = 8;
    localparam int TPU_BITS_C  = 16;
    localparam int TPU_DATAW   = 64;
    localparam int TPU_ADDRW   = 16;

    // Byte addresses of the register regions (8-byte word granularity)
    localparam int ADDR_A      = 'h100;
    localparam int ADDR_B      = 'h200;
    localparam int ADDR_C      = 'h300;
    localparam int ADDR_CMD    = 'h400;
    localparam int ADDR_STATUS = 'h408;
    localparam int ADDR_PERF   = 'h410;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CLEAR   = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Host words needed to hold one matrix row of dim elements of bits each
    function automatic int words_per_row(input int dim, input int bits, input int dataw);
        return (dim * bits) / dataw;
    endfunction

    // Index width for n entries, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int TPU_WA    = words_per_row(TPU_DIM, TPU_BITS_AB, TPU_DATAW);
    localparam int TPU_WC    = words_per_row(TPU_DIM, TPU_BITS_C, TPU_DATAW);
    localparam int TPU_ROW_W = idx_w(TPU_DIM);

endpackage

// File: rtl/tpuv2_skew_feed.sv
// tpuv2_skew_feed
// Combinational skew generator for the systolic array edges. At step i_t,
// row i of the left edge sees A[i][i_t-i] and column j of the top edge sees
// B[i_t-j][j]; positions outside the matrix are driven with zero.
// Ports:
//   i_en   - feed enable (COMPUTE); outputs are zero when low
//   i_t    - step counter
//   i_a    - A matrix, element [r][c] at bit offset (r*DIM+c)*BITS_AB
//   i_b    - B matrix, same packing as i_a
//   o_a    - left-edge inputs, row i at bit offset i*BITS_AB
//   o_b    - top-edge inputs, column j at bit offset j*BITS_AB
module tpuv2_skew_feed #(
    parameter int DIM     = 8,
    parameter int BITS_AB = 8,
    parameter int T_W     = 5
) (
    input  logic                         i_en,
    input  logic [T_W-1:0]               i_t,
    input  logic [DIM*DIM*BITS_AB-1:0]   i_a,
    input  logic [DIM*DIM*BITS_AB-1:0]   i_b,
    output logic [DIM*BITS_AB-1:0]       o_a,
    output logic [DIM*BITS_AB-1:0]       o_b
);

    always_comb begin
        o_a = '0;
        o_b = '0;
        if (i_en) begin
            for (int i = 0; i < DIM; i++) begin
                for (int k = 0; k < DIM; k++) begin
                    // Element k of row/column i is due on the edge at step i+k
                    if (int'(i_t) == i + k) begin
                        o_a[i*BITS_AB +: BITS_AB] = i_a[(i*DIM + k)*BITS_AB +: BITS_AB];
                        o_b[i*BITS_AB +: BITS_AB] = i_b[(k*DIM + i)*BITS_AB +: BITS_AB];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/tpuv2_ctrl.sv
// tpuv2_ctrl
// Memory-mapped front end for a DIM x DIM systolic MAC array. Holds the A/B
// operand matrices, packs multi-word C row writes, exposes C rows and a
// status word for reads, and sequences a matmul (optional clear, skewed
// operand feed, completion count).
// Optional feature: define TPU_PERF_EN to add a 32-bit busy-cycle counter
// readable at PERF; without it PERF reads 0.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   addr       - host byte address, r_w = 1 writes dataIn this cycle
//   dataOut    - read data, combinational from addr
//   busy       - FSM not IDLE
//   arr_en     - array shift/MAC enable
//   arr_a/b    - left-edge A / top-edge B operands
//   arr_c_wr   - write arr_cin into C row arr_crow
//   arr_crow   - C row select for reads and writes
//   arr_cin    - C row write data; arr_cout - C row read data
module tpuv2_ctrl
    import tpuv2_pkg::*;
#(
    parameter int DIM     = TPU_DIM,
    parameter int BITS_AB = TPU_BITS_AB,
    parameter int BITS_C  = TPU_BITS_C,
    parameter int DATAW   = TPU_DATAW,
    parameter int ADDRW   = TPU_ADDRW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDRW-1:0]            addr,
    input  logic                        r_w,
    input  logic [DATAW-1:0]            dataIn,
    output logic [DATAW-1:0]            dataOut,
    output logic                        busy,
    output logic                        arr_en,
    output logic [DIM*BITS_AB-1:0]      arr_a,
    output logic [DIM*BITS_AB-1:0]      arr_b,
    output logic                        arr_c_wr,
    output logic [idx_w(DIM)-1:0]       arr_crow,
    output logic [DIM*BITS_C-1:0]       arr_cin,
    input  logic [DIM*BITS_C-1:0]       arr_cout
);

    localparam int WA     = words_per_row(DIM, BITS_AB, DATAW);
    localparam int WC     = words_per_row(DIM, BITS_C, DATAW);
    localparam int ROW_W  = idx_w(DIM);
    localparam int WA_W   = idx_w(WA);
    localparam int WC_W   = idx_w(WC);
    localparam int T_W    = idx_w(3*DIM - 2);
    localparam int ROWB_A = DIM * BITS_AB;

    state_t              r_state, w_state_nxt;
    logic [T_W-1:0]      r_t, w_t_nxt;
    logic [15:0]         r_count;
    logic [ROWB_A-1:0]   r_a [DIM];
    logic [ROWB_A-1:0]   r_b [DIM];
    logic [DIM*ROWB_A-1:0] w_a_flat, w_b_flat;
    logic [DIM*BITS_C-1:0] w_cin_wr;

    // Address decode
    int w_off_a, w_off_b, w_off_c;
    logic w_hit_a, w_hit_b, w_hit_c, w_wr_ok, w_cmd;
    logic [ROW_W-1:0] w_a_row, w_b_row, w_c_row;
    logic [WA_W-1:0]  w_a_word, w_b_word;
    logic [WC_W-1:0]  w_c_word;

    assign w_off_a  = int'(addr) - ADDR_A;
    assign w_off_b  = int'(addr) - ADDR_B;
    assign w_off_c  = int'(addr) - ADDR_C;
    assign w_hit_a  = (w_off_a >= 0) && (w_off_a < DIM*WA*8);
    assign w_hit_b  = (w_off_b >= 0) && (w_off_b < DIM*WA*8);
    assign w_hit_c  = (w_off_c >= 0) && (w_off_c < DIM*WC*8);
    assign w_a_row  = ROW_W'((w_off_a / 8) / WA);
    assign w_a_word = WA_W'((w_off_a / 8) % WA);
    assign w_b_row  = ROW_W'((w_off_b / 8) / WA);
    assign w_b_word = WA_W'((w_off_b / 8) % WA);
    assign w_c_row  = ROW_W'((w_off_c / 8) / WC);
    assign w_c_word = WC_W'((w_off_c / 8) % WC);

    // Host writes only take effect while IDLE; reset also masks them
    assign w_wr_ok = r_w && !rst && (r_state == IDLE);
    assign w_cmd   = w_wr_ok && (int'(addr) == ADDR_CMD);
    assign busy    = (r_state != IDLE);

    // Operand storage
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else if (w_wr_ok) begin
            for (int w = 0; w < WA; w++) begin
                if (w_hit_a && w_a_word == WA_W'(w))
                    r_a[w_a_row][w*DATAW +: DATAW] <= dataIn;
                if (w_hit_b && w_b_word == WA_W'(w))
                    r_b[w_b_row][w*DATAW +: DATAW] <= dataIn;
            end
        end
    end

    always_comb begin
        w_a_flat = '0;
        w_b_flat = '0;
        for (int i = 0; i < DIM; i++) begin
            w_a_flat[i*ROWB_A +: ROWB_A] = r_a[i];
            w_b_flat[i*ROWB_A +: ROWB_A] = r_b[i];
        end
    end

    // C row packing: lower words wait in staging, the top word commits the row
    generate
        if (WC > 1) begin : g_stage
            logic [(WC-1)*DATAW-1:0] r_stage;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_stage <= '0;
                end else if (w_wr_ok && w_hit_c) begin
                    for (int w = 0; w < WC-1; w++) begin
                        if (w_c_word == WC_W'(w))
                            r_stage[w*DATAW +: DATAW] <= dataIn;
                    end
                end
            end
            assign w_cin_wr = {dataIn, r_stage};
        end else begin : g_nostage
            assign w_cin_wr = dataIn;
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            if (r_state == DONE)
                r_count <= r_count + 16'd1;
        end
    end

    // FSM next state; r_t is the row index in CLEAR and the feed step in COMPUTE
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        case (r_state)
            IDLE: begin
                if (w_cmd) begin
                    w_state_nxt = dataIn[0] ? COMPUTE : CLEAR;
                    w_t_nxt     = '0;
                end
            end
            CLEAR: begin
                if (r_t == T_W'(DIM-1)) begin
                    w_state_nxt = COMPUTE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            COMPUTE: begin
                if (r_t == T_W'(3*DIM-3)) begin
                    w_state_nxt = DONE;
                    w_t_nxt     = '0;
                end else begin
                    w_t_nxt = r_t + 1'b1;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Array C-port control
    always_comb begin
        arr_c_wr = 1'b0;
        arr_crow = '0;
        arr_cin  = '0;
        arr_en   = (r_state == COMPUTE);
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    arr_crow = w_c_row;
                    if (w_wr_ok && w_hit_c && w_c_word == WC_W'(WC-1)) begin
                        arr_c_wr = 1'b1;
                        arr_cin  = w_cin_wr;
                    end
                end
            end
            CLEAR: begin
                arr_c_wr = 1'b1;
                arr_crow = r_t[ROW_W-1:0];
            end
            default: ;
        endcase
    end

    tpuv2_skew_feed #(
        .DIM     (DIM),
        .BITS_AB (BITS_AB),
        .T_W     (T_W)
    ) u_skew_feed (
        .i_en (r_state == COMPUTE),
        .i_t  (r_t),
        .i_a  (w_a_flat),
        .i_b  (w_b_flat),
        .o_a  (arr_a),
        .o_b  (arr_b)
    );

`ifdef TPU_PERF_EN
    // Busy-cycle counter: restarts on an accepted command, holds once IDLE
    logic [31:0] r_perf;
    always_ff @(posedge clk) begin
        if (rst)
            r_perf <= '0;
        else if (w_cmd)
            r_perf <= '0;
        else if (r_state != IDLE)
            r_perf <= r_perf + 32'd1;
    end
`endif

    // Read mux
    always_comb begin
        dataOut = '0;
        if (w_hit_c) begin
            for (int w = 0; w < WC; w++) begin
                if (w_c_word == WC_W'(w))
                    dataOut = arr_cout[w*DATAW +: DATAW];
            end
        end else if (int'(addr) == ADDR_STATUS) begin
            dataOut[31:16] = r_count;
            dataOut[0]     = busy;
        end
`ifdef TPU_PERF_EN
        else if (int'(addr) == ADDR_PERF) begin
            dataOut = DATAW'(r_perf);
        end
`endif
    end

endmodule

// File: tb/tb_tpuv2_ctrl.sv
// tb_tpuv2_ctrl
// Directed bench for tpuv2_ctrl with a behavioural 8x8 systolic array
// attached to the arr_* ports (A flows right, B flows down, C accumulates).
module tb_tpuv2_ctrl;

    localparam int DIM = 8;

    logic          clk;
    logic          rst;
    logic [15:0]   addr;
    logic          r_w;
    logic [63:0]   dataIn;
    logic [63:0]   dataOut;
    logic          busy;
    logic          arr_en;
    logic [63:0]   arr_a;
    logic [63:0]   arr_b;
    logic          arr_c_wr;
    logic [2:0]    arr_crow;
    logic [127:0]  arr_cin;
    logic [127:0]  arr_cout;

    int n_checks = 0;
    int n_errors = 0;
    logic cwr_seen;

    tpuv2_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .r_w      (r_w),
        .dataIn   (dataIn),
        .dataOut  (dataOut),
        .busy     (busy),
        .arr_en   (arr_en),
        .arr_a    (arr_a),
        .arr_b    (arr_b),
        .arr_c_wr (arr_c_wr),
        .arr_crow (arr_crow),
        .arr_cin  (arr_cin),
        .arr_cout (arr_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural systolic array
    logic signed [15:0] m_c  [DIM][DIM];
    logic signed [7:0]  m_ah [DIM][DIM];
    logic signed [7:0]  m_bv [DIM][DIM];
    logic signed [7:0]  m_ain [DIM][DIM];
    logic signed [7:0]  m_bin [DIM][DIM];

    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            m_ain[i][0] = arr_a[i*8 +: 8];
            m_bin[0][i] = arr_b[i*8 +: 8];
            for (int j = 1; j < DIM; j++) begin
                m_ain[i][j] = m_ah[i][j-1];
                m_bin[j][i] = m_bv[j-1][i];
            end
        end
    end

    always_comb begin
        arr_cout = '0;
        for (int j = 0; j < DIM; j++)
            arr_cout[j*16 +: 16] = m_c[arr_crow][j];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DIM; i++)
                for (int j = 0; j < DIM; j++) begin
                    m_c[i][j]  <= '0;
                    m_ah[i][j] <= '0;
                    m_bv[i][j] <= '0;
                end
        end else begin
            if (arr_c_wr)
                for (int j = 0; j < DIM; j++)
                    m_c[arr_crow][j] <= arr_cin[j*16 +: 16];
            if (arr_en)
                for (int i = 0; i < DIM; i++)
                    for (int j = 0; j < DIM; j++) begin
                        m_ah[i][j] <= m_ain[i][j];
                        m_bv[i][j] <= m_bin[i][j];
                        m_c[i][j]  <= m_c[i][j] + m_ain[i][j] * m_bin[i][j];
                    end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_wr(input logic [15:0] a, input logic [63:0] d);
        @(negedge clk);
        addr   = a;
        dataIn = d;
        r_w    = 1'b1;
        #1 cwr_seen = arr_c_wr;
        @(negedge clk);
        r_w = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [63:0] d);
        @(negedge clk);
        addr = a;
        r_w  = 1'b0;
        #1 d = dataOut;
    endtask

    task automatic wait_idle(input int max_cyc, output int n);
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
    endtask

    // A row with a single 1 on the diagonal
    function automatic logic [63:0] ident_row(input int r);
        logic [63:0] v;
        v = '0;
        v[r*8 +: 8] = 8'd1;
        return v;
    endfunction

    // B[r][c] = r*8 + c
    function automatic logic [63:0] b_row(input int r);
        logic [63:0] v;
        for (int c = 0; c < DIM; c++)
            v[c*8 +: 8] = 8'(r*8 + c);
        return v;
    endfunction

    // Expected C word w of row r when C = mult * B
    function automatic logic [63:0] exp_c(input int r, input int w, input int mult);
        logic [63:0] v;
        for (int e = 0; e < 4; e++)
            v[e*16 +: 16] = 16'(mult * (r*8 + w*4 + e));
        return v;
    endfunction

    task automatic check_c_all(input string tag, input int mult);
        logic [63:0] d;
        for (int r = 0; r < DIM; r++)
            for (int w = 0; w < 2; w++) begin
                bus_rd(16'(16'h300 + (r*2 + w)*8), d);
                check(tag, d, exp_c(r, w, mult));
            end
    endtask

    initial begin
        logic [63:0] d;
        int n;

        rst    = 1'b1;
        addr   = '0;
        r_w    = 1'b0;
        dataIn = '0;
        cwr_seen = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_en",    64'(arr_en), 64'd0);
        check("rst_cwr",   64'(arr_c_wr), 64'd0);
        check("rst_arr_a", arr_a, 64'd0);
        check("rst_arr_b", arr_b, 64'd0);
        check_c_all("rst_c", 0);
        bus_rd(16'h408, d); check("rst_status", d, 64'd0);

        // Load identity A and B
        for (int r = 0; r < DIM; r++) begin
            bus_wr(16'(16'h100 + r*8), ident_row(r));
            bus_wr(16'(16'h200 + r*8), b_row(r));
        end
        bus_rd(16'h100, d); check("a_read_zero", d, 64'd0);
        bus_rd(16'h500, d); check("unmapped_zero", d, 64'd0);

        // Clear-mode matmul: C = I*B
        bus_wr(16'h400, 64'd0);
        wait_idle(200, n);
        check("busy_clear", 64'(n), 64'd31);
        check_c_all("c_eq_b", 1);
        bus_rd(16'h408, d); check("status_1", d, 64'h0000_0000_0001_0000);

        // Accumulate: C = B + I*B
        bus_wr(16'h400, 64'd1);
        wait_idle(200, n);
        check("busy_acc", 64'(n), 64'd23);
        check_c_all("c_eq_2b", 2);
        bus_rd(16'h408, d); check("status_2", d, 64'h0000_0000_0002_0000);

        // Two-word C row write
        bus_wr(16'h310, 64'h1111_2222_3333_8444);
        check("cwr_lo", 64'(cwr_seen), 64'd0);
        bus_wr(16'h318, 64'hFFFF_0005_A5A5_0077);
        check("cwr_hi", 64'(cwr_seen), 64'd1);
        bus_rd(16'h310, d); check("crow1_lo", d, 64'h1111_2222_3333_8444);
        bus_rd(16'h318, d); check("crow1_hi", d, 64'hFFFF_0005_A5A5_0077);
        bus_rd(16'h300, d); check("crow0_keep", d, exp_c(0, 0, 2));

        // Writes while busy are ignored
        bus_wr(16'h400, 64'd0);
        check("busy_after_cmd", 64'(busy), 64'd1);
        bus_wr(16'h100, 64'h02);
        bus_wr(16'h400, 64'd1);
        repeat (8) @(negedge clk);
        bus_wr(16'h318, 64'h0123_4567_89AB_CDEF);
        check("cwr_busy", 64'(cwr_seen), 64'd0);
        wait_idle(200, n);
        check("busy_drop", 64'(busy), 64'd0);
        check_c_all("c_busy_ign", 1);
        bus_rd(16'h408, d); check("status_3", d, 64'h0000_0000_0003_0000);

        // Busy-cycle counter after a clear-mode run
        bus_wr(16'h400, 64'd0);
        wait_idle(200, n);
`ifdef TPU_PERF_EN
        bus_rd(16'h410, d); check("perf", d, 64'd31);
`else
        bus_rd(16'h410, d); check("perf_absent", d, 64'd0);
`endif

        // Reset during COMPUTE
        bus_wr(16'h400, 64'd1);
        repeat (12) @(negedge clk);
        check("busy_mid", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("busy_rst", 64'(busy), 64'd0);
        rst = 1'b0;
        check_c_all("c_after_rst", 0);
        bus_rd(16'h408, d); check("status_rst", d, 64'd0);

        // CMD in the same cycle as reset
        @(negedge clk);
        rst    = 1'b1;
        addr   = 16'h400;
        dataIn = 64'd0;
        r_w    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        r_w = 1'b0;
        check("rst_wins", 64'(busy), 64'd0);
        @(negedge clk);
        check("rst_wins_2", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
